// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one unified instruction/data memory port between the
//             multicycle CPU and a second master (DMA / debug loader).
//             One access in flight; sequences read latency; 1-cycle ack per
//             access; combinational CPU stall.
//  Config   : MEMARB_FIXED_PRIO_EN - when defined the CPU always wins ties
//             and the DMA is granted only while cpu_req is low. When
//             undefined, ties alternate round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 0
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_adr_i,
    input  logic [DW-1:0] cpu_wd_i,
    output logic [DW-1:0] cpu_rd_o,
    output logic          cpu_ack_o,
    output logic          cpu_stall_o,
    input  logic          dma_req_i,
    input  logic          dma_we_i,
    input  logic [AW-1:0] dma_adr_i,
    input  logic [DW-1:0] dma_wd_i,
    output logic [DW-1:0] dma_rd_o,
    output logic          dma_ack_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_adr_o,
    output logic [DW-1:0] mem_wd_o,
    input  logic [DW-1:0] mem_rd_i
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_WAIT   = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    localparam logic c_OWN_CPU = 1'b0;
    localparam logic c_OWN_DMA = 1'b1;

    // Reload value for the wait counter; clamped so RD_LAT=0 stays in range.
    localparam logic [2:0] c_LAT_M1 = (RD_LAT == 0) ? 3'd0 : 3'(RD_LAT - 1);

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          w_any_req;
    logic          w_winner;
    logic          w_own_we;
    logic [AW-1:0] w_own_adr;
    logic [DW-1:0] w_own_wd;
    logic          w_busy;

    assign w_any_req = cpu_req_i | dma_req_i;

    // Owner's request fields are taken live; masters hold them stable until ack.
    assign w_own_we  = (owner_q == c_OWN_DMA) ? dma_we_i  : cpu_we_i;
    assign w_own_adr = (owner_q == c_OWN_DMA) ? dma_adr_i : cpu_adr_i;
    assign w_own_wd  = (owner_q == c_OWN_DMA) ? dma_wd_i  : cpu_wd_i;

`ifdef MEMARB_FIXED_PRIO_EN
    // CPU always wins; DMA only gets the port while the CPU is not asking.
    assign w_winner = cpu_req_i ? c_OWN_CPU : c_OWN_DMA;
`else
    logic last_owner_q;

    // Remember who was granted last so a tie goes to the other master.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_owner_q <= c_OWN_DMA;
        end else if (state_q == c_ST_IDLE && w_any_req) begin
            last_owner_q <= w_winner;
        end
    end

    // A lone requester wins; a tie goes to whoever was not served last.
    assign w_winner = (cpu_req_i & dma_req_i) ? ~last_owner_q : dma_req_i;
`endif

    // Access sequencer: IDLE -> ACCESS -> [WAIT x RD_LAT] -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    owner_d = w_winner;
                    state_d = c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: begin
                if (w_own_we || RD_LAT == 0) begin
                    if (!w_own_we) begin
                        rdata_d = mem_rd_i;
                    end
                    state_d = c_ST_DONE;
                end else begin
                    cnt_d   = c_LAT_M1;
                    state_d = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    rdata_d = mem_rd_i;
                    state_d = c_ST_DONE;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any access in flight immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= c_ST_IDLE;
            owner_q <= c_OWN_CPU;
            cnt_q   <= 3'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory side: address held across ACCESS/WAIT, write strobe only in ACCESS.
    assign w_busy    = (state_q == c_ST_ACCESS) || (state_q == c_ST_WAIT);
    assign mem_we_o  = (state_q == c_ST_ACCESS) & w_own_we;
    assign mem_adr_o = w_busy ? w_own_adr : '0;
    assign mem_wd_o  = w_busy ? w_own_wd  : '0;

    // Master side: ack and read data only toward the owner, only in DONE.
    assign cpu_ack_o   = (state_q == c_ST_DONE) && (owner_q == c_OWN_CPU);
    assign dma_ack_o   = (state_q == c_ST_DONE) && (owner_q == c_OWN_DMA);
    assign cpu_rd_o    = cpu_ack_o ? rdata_q : '0;
    assign dma_rd_o    = dma_ack_o ? rdata_q : '0;
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench; one instance with RD_LAT=0 and
//             one with RD_LAT=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance with RD_LAT = 0
    logic        rst0 = 1'b1;
    logic        a_creq = 0, a_cwe = 0, a_dreq = 0, a_dwe = 0;
    logic [31:0] a_cadr = 0, a_cwd = 0, a_dadr = 0, a_dwd = 0, a_mrd = 0;
    logic [31:0] a_crd, a_drd, a_madr, a_mwd;
    logic        a_cack, a_cstall, a_dack, a_mwe;

    // Instance with RD_LAT = 2
    logic        rst2 = 1'b1;
    logic        b_creq = 0, b_cwe = 0, b_dreq = 0, b_dwe = 0;
    logic [31:0] b_cadr = 0, b_cwd = 0, b_dadr = 0, b_dwd = 0, b_mrd = 0;
    logic [31:0] b_crd, b_drd, b_madr, b_mwd;
    logic        b_cack, b_cstall, b_dack, b_mwe;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(0)) u_dut0 (
        .clk_i(clk), .reset_i(rst0),
        .cpu_req_i(a_creq), .cpu_we_i(a_cwe), .cpu_adr_i(a_cadr), .cpu_wd_i(a_cwd),
        .cpu_rd_o(a_crd), .cpu_ack_o(a_cack), .cpu_stall_o(a_cstall),
        .dma_req_i(a_dreq), .dma_we_i(a_dwe), .dma_adr_i(a_dadr), .dma_wd_i(a_dwd),
        .dma_rd_o(a_drd), .dma_ack_o(a_dack),
        .mem_we_o(a_mwe), .mem_adr_o(a_madr), .mem_wd_o(a_mwd), .mem_rd_i(a_mrd)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(2)) u_dut2 (
        .clk_i(clk), .reset_i(rst2),
        .cpu_req_i(b_creq), .cpu_we_i(b_cwe), .cpu_adr_i(b_cadr), .cpu_wd_i(b_cwd),
        .cpu_rd_o(b_crd), .cpu_ack_o(b_cack), .cpu_stall_o(b_cstall),
        .dma_req_i(b_dreq), .dma_we_i(b_dwe), .dma_adr_i(b_dadr), .dma_wd_i(b_dwd),
        .dma_rd_o(b_drd), .dma_ack_o(b_dack),
        .mem_we_o(b_mwe), .mem_adr_o(b_madr), .mem_wd_o(b_mwd), .mem_rd_i(b_mrd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle0(input string tag);
        check({tag, " mem_we"},  {31'd0, a_mwe}, 32'd0);
        check({tag, " mem_adr"}, a_madr, 32'd0);
        check({tag, " mem_wd"},  a_mwd, 32'd0);
        check({tag, " cpu_ack"}, {31'd0, a_cack}, 32'd0);
        check({tag, " dma_ack"}, {31'd0, a_dack}, 32'd0);
        check({tag, " cpu_rd"},  a_crd, 32'd0);
        check({tag, " dma_rd"},  a_drd, 32'd0);
        check({tag, " stall"},   {31'd0, a_cstall}, 32'd0);
    endtask

    initial begin
        // ---- 1: reset, no requests ----
        #1;
        check_idle0("rst_hold");
        step();
        step();
        rst0 = 1'b0;
        rst2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle0("post_rst");
        end

        // ---- 2: CPU read, RD_LAT=0 ----
        a_creq = 1; a_cwe = 0; a_cadr = 32'h40; a_mrd = 32'hDEADBEEF;
        #1;
        check("t2 c0 stall", {31'd0, a_cstall}, 32'd1);
        check("t2 c0 madr",  a_madr, 32'd0);
        step();
        check("t2 c1 madr",  a_madr, 32'h40);
        check("t2 c1 mwe",   {31'd0, a_mwe}, 32'd0);
        check("t2 c1 stall", {31'd0, a_cstall}, 32'd1);
        check("t2 c1 ack",   {31'd0, a_cack}, 32'd0);
        step();
        check("t2 c2 ack",   {31'd0, a_cack}, 32'd1);
        check("t2 c2 rd",    a_crd, 32'hDEADBEEF);
        check("t2 c2 stall", {31'd0, a_cstall}, 32'd0);
        check("t2 c2 dack",  {31'd0, a_dack}, 32'd0);
        check("t2 c2 drd",   a_drd, 32'd0);
        a_creq = 0;
        step();
        check("t2 c3 ack",   {31'd0, a_cack}, 32'd0);
        check("t2 c3 rd",    a_crd, 32'd0);

        // ---- 3: DMA write, RD_LAT=0 ----
        a_dreq = 1; a_dwe = 1; a_dadr = 32'h100; a_dwd = 32'h12345678; a_mrd = 32'h0;
        #1;
        check("t3 c0 mwe", {31'd0, a_mwe}, 32'd0);
        step();
        check("t3 c1 mwe",  {31'd0, a_mwe}, 32'd1);
        check("t3 c1 madr", a_madr, 32'h100);
        check("t3 c1 mwd",  a_mwd, 32'h12345678);
        check("t3 c1 dack", {31'd0, a_dack}, 32'd0);
        step();
        check("t3 c2 dack", {31'd0, a_dack}, 32'd1);
        check("t3 c2 mwe",  {31'd0, a_mwe}, 32'd0);
        check("t3 c2 cack", {31'd0, a_cack}, 32'd0);
        a_dreq = 0; a_dwe = 0;
        step();
        check("t3 c3 dack", {31'd0, a_dack}, 32'd0);
        check("t3 c3 mwe",  {31'd0, a_mwe}, 32'd0);

        // ---- 4: both request from reset ----
        rst0 = 1;
        a_creq = 1; a_cwe = 0; a_cadr = 32'h10;
        a_dreq = 1; a_dwe = 0; a_dadr = 32'h20;
        a_mrd = 32'h55AA00FF;
        step();
        rst0 = 0;
        for (int k = 1; k <= 12; k++) begin
            logic exp_c, exp_d;
            step();
`ifdef MEMARB_FIXED_PRIO_EN
            exp_c = ((k % 3) == 2);
            exp_d = 1'b0;
`else
            exp_c = ((k % 6) == 2);
            exp_d = ((k % 6) == 5);
`endif
            check($sformatf("t4 k%0d cack", k), {31'd0, a_cack}, {31'd0, exp_c});
            check($sformatf("t4 k%0d dack", k), {31'd0, a_dack}, {31'd0, exp_d});
            check($sformatf("t4 k%0d mwe", k),  {31'd0, a_mwe}, 32'd0);
        end
        a_creq = 0; a_dreq = 0;

        // ---- 5: CPU read, RD_LAT=2 ----
        b_creq = 1; b_cwe = 0; b_cadr = 32'h8; b_mrd = 32'h0;
        #1;
        check("t5 c0 stall", {31'd0, b_cstall}, 32'd1);
        step();
        check("t5 c1 madr", b_madr, 32'h8);
        check("t5 c1 ack",  {31'd0, b_cack}, 32'd0);
        step();
        check("t5 c2 madr", b_madr, 32'h8);
        check("t5 c2 ack",  {31'd0, b_cack}, 32'd0);
        check("t5 c2 mwe",  {31'd0, b_mwe}, 32'd0);
        step();
        b_mrd = 32'hA5A5A5A5;
        check("t5 c3 madr", b_madr, 32'h8);
        check("t5 c3 ack",  {31'd0, b_cack}, 32'd0);
        step();
        check("t5 c4 ack",   {31'd0, b_cack}, 32'd1);
        check("t5 c4 rd",    b_crd, 32'hA5A5A5A5);
        check("t5 c4 stall", {31'd0, b_cstall}, 32'd0);
        check("t5 c4 madr",  b_madr, 32'd0);
        b_creq = 0;
        step();
        check("t5 c5 ack", {31'd0, b_cack}, 32'd0);

        // ---- 6: reset in first WAIT cycle, RD_LAT=2 ----
        b_creq = 1; b_cwe = 0; b_cadr = 32'hC; b_mrd = 32'h0BADF00D;
        step();
        check("t6 c1 madr", b_madr, 32'hC);
        step();
        check("t6 c2 madr", b_madr, 32'hC);
        rst2 = 1;
        #1;
        check("t6 rst madr", b_madr, 32'd0);
        check("t6 rst ack",  {31'd0, b_cack}, 32'd0);
        check("t6 rst mwe",  {31'd0, b_mwe}, 32'd0);
        step();
        check("t6 rst2 ack", {31'd0, b_cack}, 32'd0);
        rst2 = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("t6 r%0d ack", k), {31'd0, b_cack}, {31'd0, (k == 4)});
            check($sformatf("t6 r%0d stall", k), {31'd0, b_cstall}, {31'd0, (k != 4)});
        end
        check("t6 rd", b_crd, 32'h0BADF00D);
        b_creq = 0;
        step();
        check("t6 end ack", {31'd0, b_cack}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
